// File: rtl/memory_requester.sv
// Generic FIFO: stores commands until the issue logic pops the head.
// Latency: a push is visible at the head one cycle later.
// Backpressure: full blocks pushes; pop while empty is ignored.
module memory_requester_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         full,
    input  logic         pop_rdy,
    output logic [W-1:0] head_dat,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = push_vld && !full;
    assign pop      = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// Memory requester: queues commands, issues them in order under an outstanding limit, retires tagged returns.
// Latency: accepted command issues one cycle later at best; a return retires on the edge that samples it.
// Backpressure: cmd_ready drops when the FIFO is full; the head stalls on MAX_OUT or a tag already in flight.
module memory_requester #(
    parameter int MAX_OUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [15:0] cmd_address,
    input  logic [15:0] cmd_data,
    output logic        wr_en,
    output logic [15:0] wr_address,
    output logic [15:0] wr_data,
    output logic        rd_en,
    output logic [15:0] rd_address,
    input  logic        wr_ret_ack,
    input  logic [15:0] wr_ret_address,
    input  logic        rd_ret_ack,
    input  logic [15:0] rd_ret_address,
    input  logic [15:0] rd_ret_data,
    output logic        wr_done,
    output logic [15:0] wr_done_address,
    output logic        rd_done,
    output logic [15:0] rd_done_address,
    output logic [15:0] rd_done_data,
    output logic [3:0]  outstanding,
    output logic        err_unmatched
);
    localparam int IW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef struct packed {
        logic        write;
        logic [15:0] address;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        logic        vld;
        logic        write;
        logic [15:0] address;
    } entry_t;

    entry_t        ent_q [MAX_OUT];
    cmd_t          cmd_dat;
    cmd_t          head;
    logic          ready_q;
    logic          fifo_full;
    logic          fifo_empty;
    logic          issue_vld;
    logic [3:0]    cnt;
    logic          addr_hit;
    logic          free_found;
    logic [IW-1:0] free_idx;
    logic          wr_hit;
    logic [IW-1:0] wr_idx;
    logic          rd_hit;
    logic [IW-1:0] rd_idx;

    assign cmd_dat   = '{write: cmd_write, address: cmd_address, data: cmd_data};
    assign cmd_ready = ready_q && !fifo_full;

    memory_requester_fifo #(
        .W     ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_valid && cmd_ready),
        .push_dat (cmd_dat),
        .full     (fifo_full),
        .pop_rdy  (issue_vld),
        .head_dat (head),
        .empty    (fifo_empty)
    );

    // Holds cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Table scan: occupancy, tag collision with the head, lowest free slot and return matches.
    always_comb begin
        cnt        = '0;
        addr_hit   = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
        wr_hit     = 1'b0;
        wr_idx     = '0;
        rd_hit     = 1'b0;
        rd_idx     = '0;
        for (int i = 0; i < MAX_OUT; i++) begin
            if (ent_q[i].vld) begin
                cnt = cnt + 4'd1;
                if (ent_q[i].address == head.address) begin
                    addr_hit = 1'b1;
                end
                if (ent_q[i].write && ent_q[i].address == wr_ret_address) begin
                    wr_hit = wr_ret_ack;
                    wr_idx = IW'(i);
                end
                if (!ent_q[i].write && ent_q[i].address == rd_ret_address) begin
                    rd_hit = rd_ret_ack;
                    rd_idx = IW'(i);
                end
            end else if (!free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
    end

    assign issue_vld   = !fifo_empty && (cnt < 4'(MAX_OUT)) && !addr_hit;
    assign outstanding = cnt;

    // Retire and allocate never touch the same slot: the allocated slot is currently free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            if (wr_hit) begin
                ent_q[wr_idx].vld <= 1'b0;
            end
            if (rd_hit) begin
                ent_q[rd_idx].vld <= 1'b0;
            end
            if (issue_vld) begin
                ent_q[free_idx] <= '{vld: 1'b1, write: head.write, address: head.address};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en           <= 1'b0;
            wr_address      <= '0;
            wr_data         <= '0;
            rd_en           <= 1'b0;
            rd_address      <= '0;
            wr_done         <= 1'b0;
            wr_done_address <= '0;
            rd_done         <= 1'b0;
            rd_done_address <= '0;
            rd_done_data    <= '0;
            err_unmatched   <= 1'b0;
        end else begin
            wr_en   <= issue_vld && head.write;
            rd_en   <= issue_vld && !head.write;
            wr_done <= wr_hit;
            rd_done <= rd_hit;
            if (issue_vld && head.write) begin
                wr_address <= head.address;
                wr_data    <= head.data;
            end
            if (issue_vld && !head.write) begin
                rd_address <= head.address;
            end
            if (wr_hit) begin
                wr_done_address <= wr_ret_address;
            end
            if (rd_hit) begin
                rd_done_address <= rd_ret_address;
                rd_done_data    <= rd_ret_data;
            end
            if ((wr_ret_ack && !wr_hit) || (rd_ret_ack && !rd_hit)) begin
                err_unmatched <= 1'b1;
            end
        end
    end
endmodule
